// File: rtl/data_depuncturer_if.sv
// Bit-stream bus for the 802.11a depuncturer: coded bits in, depunctured A/B pairs
// with erasure flags out.
interface data_depuncturer_if;
    logic [3:0] rate;
    logic       in;
    logic       in_valid;
    logic       out_a;
    logic       out_b;
    logic       era_a;
    logic       era_b;
    logic       out_valid;
    logic       sig_done;

    modport master (
        output rate, in, in_valid,
        input  out_a, out_b, era_a, era_b, out_valid, sig_done
    );

    modport slave (
        input  rate, in, in_valid,
        output out_a, out_b, era_a, era_b, out_valid, sig_done
    );
endinterface

// File: rtl/data_depuncturer.sv
// 802.11a depuncturer: rebuilds rate-1/2 (A,B) pairs with erasure flags from the
// deinterleaved bit stream, SIGNAL field at 1/2, DATA at the latched RATE.
module data_depuncturer (
    input  logic                  Clk,
    input  logic                  reset,
    data_depuncturer_if.slave     bus
);
    localparam int unsigned RATE_W  = 4;
    localparam int unsigned PHASE_W = 2;
    localparam int unsigned PAIR_W  = 5;
    localparam logic [PAIR_W-1:0] SIG_LAST_PAIR = PAIR_W'(23);

    typedef enum logic { SIG, DAT } state_t;
    typedef enum logic [1:0] { CR_12, CR_23, CR_34 } code_rate_t;

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [PAIR_W-1:0]   pair_q, pair_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic                a_q, a_d;
    logic                out_a_q, out_a_d;
    logic                out_b_q, out_b_d;
    logic                era_a_q, era_a_d;
    logic                era_b_q, era_b_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    code_rate_t          cr;

    function automatic code_rate_t decode_rate(input logic [RATE_W-1:0] r);
        code_rate_t c;
        case (r)
            4'b0001:                            c = CR_23;
            4'b1111, 4'b0111, 4'b1011, 4'b0011: c = CR_34;
            default:                            c = CR_12;
        endcase
        return c;
    endfunction

    // State and output registers
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q <= SIG;
            phase_q <= '0;
            pair_q  <= '0;
            rate_q  <= '0;
            a_q     <= 1'b0;
            out_a_q <= 1'b0;
            out_b_q <= 1'b0;
            era_a_q <= 1'b0;
            era_b_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pair_q  <= pair_d;
            rate_q  <= rate_d;
            a_q     <= a_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            era_a_q <= era_a_d;
            era_b_q <= era_b_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state and pair assembly; everything holds unless a valid bit arrives
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pair_d  = pair_q;
        rate_d  = rate_q;
        a_d     = a_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        era_a_d = era_a_q;
        era_b_d = era_b_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        cr      = (state_q == SIG) ? CR_12 : decode_rate(rate_q);

        if (bus.in_valid) begin
            phase_d = phase_q + PHASE_W'(1);
            case (phase_q)
                2'd0: a_d = bus.in;
                2'd1: begin
                    {out_a_d, out_b_d, era_a_d, era_b_d} = {a_q, bus.in, 2'b00};
                    valid_d = 1'b1;
                    if (cr == CR_12) phase_d = '0;
                end
                2'd2: begin
                    {out_a_d, out_b_d, era_a_d, era_b_d} = {bus.in, 1'b0, 2'b01};
                    valid_d = 1'b1;
                    if (cr == CR_23) phase_d = '0;
                end
                default: begin
                    {out_a_d, out_b_d, era_a_d, era_b_d} = {1'b0, bus.in, 2'b10};
                    valid_d = 1'b1;
                    phase_d = '0;
                end
            endcase

            // The 24th SIGNAL pair hands over to DATA and latches the rate there
            if (state_q == SIG && valid_d) begin
                pair_d = pair_q + PAIR_W'(1);
                if (pair_q == SIG_LAST_PAIR) begin
                    done_d  = 1'b1;
                    state_d = DAT;
                    rate_d  = bus.rate;
                    phase_d = '0;
                    pair_d  = '0;
                end
            end
        end
    end

    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.era_a     = era_a_q;
    assign bus.era_b     = era_b_q;
    assign bus.out_valid = valid_q;
    assign bus.sig_done  = done_q;
endmodule

// File: tb/tb_data_depuncturer.sv
// Directed bench for data_depuncturer: SIGNAL field, 3/4 and 2/3 DATA, gaps,
// rate latching and reset behaviour.
module tb_data_depuncturer;
    logic Clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [3:0] hold;

    data_depuncturer_if dif ();

    data_depuncturer dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One input cycle: drive just after a falling edge, return at the next one
    task automatic cyc(input logic v, input logic b);
        dif.in_valid = v;
        dif.in       = b;
        @(negedge Clk);
    endtask

    // Compare {out_valid, out_a, out_b, era_a, era_b, sig_done}; pair fields hold when no pair
    task automatic chk(input string tag, input logic ev, input logic [3:0] ep, input logic ed);
        logic [5:0] obs;
        logic [5:0] expv;
        if (ev) hold = ep;
        obs  = {dif.out_valid, dif.out_a, dif.out_b, dif.era_a, dif.era_b, dif.sig_done};
        expv = {ev, hold, ed};
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed v,a,b,ea,eb,done=%b required %b", tag, obs, expv);
        end
    endtask

    // SIGNAL field 1,0,1,0,... with optional idle cycles after every bit
    task automatic signal_field(input int gap, input string tag);
        for (int i = 0; i < 48; i++) begin
            cyc(1'b1, (i % 2) == 0);
            chk($sformatf("%s_bit%0d", tag, i), (i % 2) == 1, 4'b1000, i == 47);
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 1'b1);
                chk($sformatf("%s_gap%0d_%0d", tag, i, g), 1'b0, 4'b0000, 1'b0);
            end
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        hold         = 4'b0000;
        reset        = 1'b0;
        dif.rate     = 4'b0011;
        dif.in       = 1'b0;
        dif.in_valid = 1'b0;

        // Reset state, and reset beating a simultaneous valid bit
        cyc(1'b0, 1'b0);
        hold = 4'b0000;
        chk("reset_idle", 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 1'b1);
        chk("reset_with_valid_a", 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 1'b1);
        chk("reset_with_valid_b", 1'b0, 4'b0000, 1'b0);
        reset = 1'b1;

        // Contiguous SIGNAL field, rate 0011 latched at the handover
        signal_field(0, "sig_contig");
        dif.rate = 4'b0001;

        // DATA at 3/4: bits 1,1,(gap),0,1 then a fresh capture
        cyc(1'b1, 1'b1); chk("r34_b0", 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 1'b1); chk("r34_b1", 1'b1, 4'b1100, 1'b0);
        cyc(1'b0, 1'b0); chk("r34_gap", 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 1'b0); chk("r34_b2", 1'b1, 4'b0001, 1'b0);
        cyc(1'b1, 1'b1); chk("r34_b3", 1'b1, 4'b0110, 1'b0);
        cyc(1'b1, 1'b1); chk("r34_b4_capture", 1'b0, 4'b0000, 1'b0);

        // Reset mid-pair in DATA
        reset = 1'b0;
        cyc(1'b1, 1'b0);
        hold = 4'b0000;
        chk("dat_reset", 1'b0, 4'b0000, 1'b0);
        reset = 1'b1;

        // Gappy SIGNAL field, rate 0001 latched; later rate change ignored
        signal_field(3, "sig_gappy");
        dif.rate = 4'b0011;

        // DATA at 2/3: bits 1,0,1,1,1,0
        cyc(1'b1, 1'b1); chk("r23_b0", 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 1'b0); chk("r23_b1", 1'b1, 4'b1000, 1'b0);
        cyc(1'b1, 1'b1); chk("r23_b2", 1'b1, 4'b1001, 1'b0);
        cyc(1'b1, 1'b1); chk("r23_b3", 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 1'b1); chk("r23_b4", 1'b1, 4'b1100, 1'b0);
        cyc(1'b1, 1'b0); chk("r23_b5", 1'b1, 4'b0001, 1'b0);

        // Reset, SIGNAL again with rate 1001, then toggle rate to 1111 in DATA
        reset = 1'b0;
        cyc(1'b0, 1'b0);
        hold = 4'b0000;
        chk("reset_again", 1'b0, 4'b0000, 1'b0);
        reset = 1'b1;
        dif.rate = 4'b1001;
        signal_field(0, "sig_r12");
        dif.rate = 4'b1111;
        cyc(1'b1, 1'b1); chk("r12_b0", 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 1'b1); chk("r12_b1", 1'b1, 4'b1100, 1'b0);
        cyc(1'b1, 1'b0); chk("r12_b2", 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 1'b1); chk("r12_b3", 1'b1, 4'b0100, 1'b0);
        cyc(1'b1, 1'b1); chk("r12_b4", 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 1'b0); chk("r12_b5", 1'b1, 4'b1000, 1'b0);
        cyc(1'b1, 1'b0); chk("r12_b6", 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 1'b1); chk("r12_b7", 1'b1, 4'b0100, 1'b0);
        cyc(1'b0, 1'b0); chk("r12_idle", 1'b0, 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_depuncturer.md
DATA_DEPUNCTURER -- requirements
Module: data_depuncturer

Interface
REQ-001 The module SHALL have these ports:
- Clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- rate  input  4  802.11a RATE field R1..R4, with bit 3 = R1.
- in  input  1  deinterleaved coded bit.
- in_valid  input  1  marks `in` as a valid bit this cycle.
- out_a  output  1  depunctured A (upper generator) bit.
- out_b  output  1  depunctured B (lower generator) bit.
- era_a  output  1  marks out_a as an erasure (inserted, not received).
- era_b  output  1  marks out_b as an erasure.
- out_valid  output  1  the pair is valid this cycle.
- sig_done  output  1  one-cycle pulse on the last SIGNAL-field pair.

REQ-002 Reset is reset: synchronous, active-low. The clock is Clk.

Function
REQ-003 The FSM SHALL have two states:
- SIG: the first 48 valid bits after reset, always code rate 1/2.
- DAT: all bits after that, at the code rate latched from `rate`.

REQ-004 The block SHALL sample `rate` into rate_q on the cycle the FSM goes SIG->DAT; `rate` changes at any other time SHALL be ignored.

REQ-005 The code rate SHALL decode from rate_q as follows:
- 1101, 0101, 1001 -> 1/2.
- 0001 -> 2/3.
- 1111, 0111, 1011, 0011 -> 3/4.
- Any other code -> 1/2.

REQ-006 A phase counter SHALL advance by one only on cycles with in_valid=1, with wrap points:
- 1/2: period 2 bits.
- 2/3: period 3 bits.
- 3/4: period 4 bits.
- The counter SHALL wrap to 0 after the last phase.

REQ-007 At rate 1/2:
- Phase 0: capture A.
- Phase 1: emit pair (A, in); era_a=0, era_b=0.

REQ-008 At rate 2/3:
- Phase 0: capture A0.
- Phase 1: emit (A0, in); no erasures.
- Phase 2: emit (in, 0) with era_b=1.

REQ-009 At rate 3/4:
- Phase 0: capture A0.
- Phase 1: emit (A0, in); no erasures.
- Phase 2: emit (in, 0) with era_b=1.
- Phase 3: emit (0, in) with era_a=1.

REQ-010 Erased positions SHALL drive a data value of 0.

REQ-011 Output timing:
- Each emitted pair SHALL appear registered, one cycle after the in_valid cycle that completes it.
- out_valid SHALL be high for exactly that one cycle.
- At most one pair SHALL be emitted per cycle.

REQ-012 When no pair is emitted, out_valid=0; out_a, out_b, era_a and era_b SHALL hold their last values.

REQ-013 In SIG, a 5-bit pair counter SHALL count emitted pairs.
- On the 24th pair, sig_done SHALL pulse high together with out_valid.
- On that same input cycle, the FSM SHALL go to DAT, latch rate_q, and clear the phase counter to 0.

REQ-014 The first DAT bit SHALL always be treated as phase 0.

REQ-015 In DAT, the FSM SHALL stay in DAT until reset; phase SHALL wrap continuously across OFDM symbol boundaries.

REQ-016 Gaps (in_valid=0) SHALL freeze the phase counter, pair counter, FSM state and any captured A bit, for any number of cycles.

REQ-017 The block SHALL have no backpressure; every in_valid bit SHALL be consumed in the cycle it is presented.

Reset
REQ-018 While reset=0 at a rising edge, the following SHALL all be 0 on the next cycle: out_a, out_b, era_a, era_b, out_valid, sig_done, phase counter, pair counter and rate_q. The FSM SHALL be in SIG.

REQ-019 A reset during DAT SHALL discard any captured partial pair; the next valid bit after reset release SHALL be SIGNAL bit 0.

REQ-020 When reset and in_valid are asserted together, reset SHALL win and no pair SHALL be emitted.

Verification
REQ-021 The bench SHALL cover these scenarios:
- SIGNAL field: 48 contiguous valid bits 1,0,1,0,... -> 24 pairs (1,0) with no erasures; sig_done high only with pair 24; FSM goes to DAT.
- rate=0011 (3/4), DAT bits 1,1,0,1 -> pairs (1,1,e=00), (0,0,e=01), (0,1,e=10), each one cycle after its completing bit.
- rate=0001 (2/3), DAT bits 1,0,1,1,1,0 -> pairs (1,0,00), (1,0,01), (1,1,00), (0,0,01).
- Gappy input: the SIGNAL stream with in_valid=0 inserted for 3 cycles after every bit -> the same 24 pairs as the contiguous case, no extra out_valid, sig_done exactly once.
- rate toggled 1001->1111 mid-DAT -> pattern stays rate 1/2 (latched 1001); no erasures appear.
- reset=0 asserted after DAT bit 1 at rate 3/4 -> all outputs 0; the next 48 bits are decoded as SIGNAL pairs at rate 1/2.
